wdg_feed_ctrl: RTL and testbench
================================

Name: wdg_feed_ctrl

Overview:
APB4 master that boots the watchdog timer and then feeds it on behalf of NUM_SRC software/hardware heartbeat sources. It issues the key-unlocked write sequence needed to program PSCR, CMP and CTRL. A feed is issued only after every source has checked in since the previous feed, so one hung source lets the watchdog expire. It sits between the system heartbeat producers and the watchdog's APB4 slave port, on the same bus segment.

Parameters:
NUM_SRC, 4, number of heartbeat requesters (1..16)
ADDR_WIDTH, 32, APB address width
WDG_BASE, 32'h0, base address of watchdog register block
PSCR_WIDTH, 20, prescaler field width
CMP_WIDTH, 32, compare field width

Ports:
clk_i  in  1  APB clock
rst_i  in  1  asynchronous reset, active-high
start_i  in  1  pulse: begin configuration (accepted in IDLE or ERR only)
pscr_i  in  PSCR_WIDTH  prescaler value, sampled on accepted start_i
cmp_i  in  CMP_WIDTH  compare value, sampled on accepted start_i
hb_i  in  NUM_SRC  per-source heartbeat pulses
paddr_o  out  ADDR_WIDTH  APB address
psel_o  out  1  APB select
penable_o  out  1  APB enable
pwrite_o  out  1  APB write; always 1 unless WDG_FEED_CTRL_VERIFY_EN read
pwdata_o  out  32  APB write data
prdata_i  in  32  APB read data
pready_i  in  1  APB ready
pslverr_i  in  1  APB error
busy_o  out  1  transfer sequence in progress
armed_o  out  1  watchdog configured; feeding active
err_o  out  1  sticky: slave error or verify mismatch
hb_pend_o  out  NUM_SRC  sticky heartbeat flags awaiting feed
feed_cnt_o  out  16  completed feeds, wraps 0xFFFF->0

Behaviour:
- Decided: one clock clk_i; rst_i is asynchronous, active-high. Reset values: all outputs 0, paddr_o/pwdata_o 0, FSM IDLE.
- Register offsets from WDG_BASE: CTRL 0x00, PSCR 0x04, CMP 0x0C, STAT 0x10, KEY 0x14, FEED 0x18. KEY value 32'h5F37_59DF. The slave clears KEY on any non-KEY write, so every protected write is preceded by its own KEY write.
- APB engine: SETUP cycle (psel=1, penable=0), then ACCESS (psel=1, penable=1), held until pready_i=1. Addr/data/write stable SETUP through ACCESS. Min 2 cycles per transfer. Back-to-back transfers allowed with no idle cycle.
- FSM states:
  - IDLE: start_i captures pscr_i/cmp_i -> CFG.
  - CFG: 6 writes: KEY, PSCR, KEY, CMP, KEY, CTRL=0x3. With pready_i tied high this takes 12 cycles. Last write completes -> ARMED.
  - ARMED: armed_o=1. Waits until hb_pend_o all ones -> FEED.
  - FEED: 4 writes: KEY, FEED=1, KEY, FEED=0. On completion of FEED=0, feed_cnt_o+1 -> ARMED.
  - ERR: pslverr_i=1 on any completing ACCESS aborts the sequence after that transfer, sets err_o and enters ERR. start_i clears err_o and restarts CFG.
- busy_o=1 in CFG/FEED and for the duration of any transfer.
- hb_pend_o: bit set on hb_i pulse in any state except IDLE/ERR. All bits cleared in the cycle FEED is entered. If hb_i arrives in that same cycle, set wins: the bit stays 1 and counts toward the next feed.
- start_i in CFG/ARMED/FEED is ignored. There is no software stop; disabling is done by reset.
- rst_i mid-transfer: psel_o/penable_o drop immediately (async); the slave sees an aborted transfer.

Optional Feature:
WDG_FEED_CTRL_VERIFY_EN:
- Defined: after the CTRL write, CFG performs reads of CMP then CTRL (pwrite_o=0, 2 cycles each min). prdata_i is compared to the captured cmp_i and to 0x3 (CTRL bits [1:0]). On mismatch: err_o=1 -> ERR; armed_o is never asserted.
- Undefined: no reads are issued; CFG ends at the CTRL write.

Test Plan:
- Reset, start_i with pscr_i=0x20, cmp_i=0x100, pready_i=1 -> exact write order KEY/PSCR/KEY/CMP/KEY/CTRL with data 5F3759DF,0x20,5F3759DF,0x100,5F3759DF,0x3; armed_o=1 on the 13th cycle after start.
- NUM_SRC=4, pulse hb_i bits 0,1,2 only -> no FEED transfers, hb_pend_o=0b0111; pulse bit 3 -> 4 writes ending FEED=0, feed_cnt_o=1, hb_pend_o=0.
- hb_i[0] pulsed in the same cycle FEED is entered -> after the feed, hb_pend_o=0b0001.
- pready_i low for 3 cycles on the CMP write -> ACCESS held 4 cycles, paddr_o/pwdata_o stable; total CFG 15 cycles.
- pslverr_i=1 on the PSCR write -> no further transfers, err_o=1, armed_o=0. start_i restarts cleanly and err_o clears.
- rst_i asserted during FEED ACCESS -> psel_o=0 in the same cycle, all outputs 0, feed_cnt_o=0.

Source files
------------

// File: rtl/wdg_feed_ctrl.sv
// wdg_feed_ctrl: APB4 master that configures the watchdog, then feeds it once every heartbeat source has checked in.
// Latency: 2 cycles per APB transfer minimum. CFG takes 12 cycles with pready_i high; FEED takes 8 cycles.
// Backpressure: pready_i low holds ACCESS with address and data stable. Optional read-back verify: WDG_FEED_CTRL_VERIFY_EN.
module wdg_feed_ctrl #(
  parameter int                    NUM_SRC    = 4,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] WDG_BASE   = '0,
  parameter int                    PSCR_WIDTH = 20,
  parameter int                    CMP_WIDTH  = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [PSCR_WIDTH-1:0] pscr_i,
  input  logic [CMP_WIDTH-1:0]  cmp_i,
  input  logic [NUM_SRC-1:0]    hb_i,
  output logic [ADDR_WIDTH-1:0] paddr_o,
  output logic                  psel_o,
  output logic                  penable_o,
  output logic                  pwrite_o,
  output logic [31:0]           pwdata_o,
  input  logic [31:0]           prdata_i,
  input  logic                  pready_i,
  input  logic                  pslverr_i,
  output logic                  busy_o,
  output logic                  armed_o,
  output logic                  err_o,
  output logic [NUM_SRC-1:0]    hb_pend_o,
  output logic [15:0]           feed_cnt_o
);

  localparam logic [31:0] KEY_VAL  = 32'h5F37_59DF;
  localparam logic [7:0]  OFF_CTRL = 8'h00;
  localparam logic [7:0]  OFF_PSCR = 8'h04;
  localparam logic [7:0]  OFF_CMP  = 8'h0C;
  localparam logic [7:0]  OFF_KEY  = 8'h14;
  localparam logic [7:0]  OFF_FEED = 8'h18;
`ifdef WDG_FEED_CTRL_VERIFY_EN
  localparam logic [2:0]  CFG_LAST = 3'd7;
`else
  localparam logic [2:0]  CFG_LAST = 3'd5;
`endif
  localparam logic [2:0]  FEED_LAST = 3'd3;

  typedef enum logic [2:0] {
    ST_IDLE, ST_CFG, ST_ARMED, ST_FEED, ST_ERR
  } state_t;

  state_t                state_q, state_d;
  logic                  access_q, access_d;
  logic [2:0]            step_q, step_d;
  logic [PSCR_WIDTH-1:0] pscr_q, pscr_d;
  logic [CMP_WIDTH-1:0]  cmp_q, cmp_d;
  logic                  err_q, err_d;
  logic [NUM_SRC-1:0]    pend_q, pend_d;
  logic [15:0]           feed_cnt_q, feed_cnt_d;

  logic                  in_xfer;
  logic                  xfer_write;
  logic [7:0]            xfer_off;
  logic [31:0]           xfer_data;
  logic                  verify_bad;

`ifndef WDG_FEED_CTRL_VERIFY_EN
  logic                  unused_prdata;
  assign unused_prdata = ^prdata_i;
`endif

  assign in_xfer = (state_q == ST_CFG) || (state_q == ST_FEED);

  // Decode the current sequence step into the register access it performs.
  always_comb begin
    xfer_write = 1'b1;
    xfer_off   = OFF_CTRL;
    xfer_data  = 32'h0;
    if (state_q == ST_CFG) begin
      case (step_q)
        3'd0, 3'd2, 3'd4: begin xfer_off = OFF_KEY;  xfer_data = KEY_VAL;        end
        3'd1:             begin xfer_off = OFF_PSCR; xfer_data = 32'(pscr_q);    end
        3'd3:             begin xfer_off = OFF_CMP;  xfer_data = 32'(cmp_q);     end
        3'd5:             begin xfer_off = OFF_CTRL; xfer_data = 32'h3;          end
        3'd6:             begin xfer_off = OFF_CMP;  xfer_write = 1'b0;          end
        default:          begin xfer_off = OFF_CTRL; xfer_write = 1'b0;          end
      endcase
    end else if (state_q == ST_FEED) begin
      case (step_q)
        3'd1:    begin xfer_off = OFF_FEED; xfer_data = 32'h1;   end
        3'd3:    begin xfer_off = OFF_FEED; xfer_data = 32'h0;   end
        default: begin xfer_off = OFF_KEY;  xfer_data = KEY_VAL; end
      endcase
    end
  end

  // Compare read-back data against what was programmed (CMP, then CTRL enable bits).
  always_comb begin
    verify_bad = 1'b0;
`ifdef WDG_FEED_CTRL_VERIFY_EN
    if (state_q == ST_CFG && step_q == 3'd6) verify_bad = (prdata_i != 32'(cmp_q));
    if (state_q == ST_CFG && step_q == 3'd7) verify_bad = (prdata_i[1:0] != 2'b11);
`endif
  end

  // Next-state: sequence control, APB phase stepping, heartbeat collection.
  always_comb begin
    state_d    = state_q;
    access_d   = access_q;
    step_d     = step_q;
    pscr_d     = pscr_q;
    cmp_d      = cmp_q;
    err_d      = err_q;
    pend_d     = pend_q;
    feed_cnt_d = feed_cnt_q;
    case (state_q)
      ST_IDLE, ST_ERR: begin
        if (start_i) begin
          state_d  = ST_CFG;
          step_d   = 3'd0;
          access_d = 1'b0;
          pscr_d   = pscr_i;
          cmp_d    = cmp_i;
          err_d    = 1'b0;
        end
      end
      ST_CFG, ST_FEED: begin
        if (!access_q) begin
          access_d = 1'b1;
        end else if (pready_i) begin
          access_d = 1'b0;
          if (pslverr_i || verify_bad) begin
            state_d = ST_ERR;
            err_d   = 1'b1;
            step_d  = 3'd0;
          end else if (state_q == ST_CFG && step_q == CFG_LAST) begin
            state_d = ST_ARMED;
            step_d  = 3'd0;
          end else if (state_q == ST_FEED && step_q == FEED_LAST) begin
            state_d    = ST_ARMED;
            step_d     = 3'd0;
            feed_cnt_d = feed_cnt_q + 16'd1;
          end else begin
            step_d = step_q + 3'd1;
          end
        end
      end
      ST_ARMED: begin
        if (&pend_q) begin
          state_d  = ST_FEED;
          step_d   = 3'd0;
          access_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Entering FEED clears the flags; a same-cycle heartbeat still lands.
    if (state_q == ST_ARMED && (&pend_q)) pend_d = '0;
    if (state_q != ST_IDLE && state_q != ST_ERR) pend_d = pend_d | hb_i;
  end

  // State registers, cleared asynchronously so the bus drops at once on reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      access_q   <= 1'b0;
      step_q     <= 3'd0;
      pscr_q     <= '0;
      cmp_q      <= '0;
      err_q      <= 1'b0;
      pend_q     <= '0;
      feed_cnt_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      access_q   <= access_d;
      step_q     <= step_d;
      pscr_q     <= pscr_d;
      cmp_q      <= cmp_d;
      err_q      <= err_d;
      pend_q     <= pend_d;
      feed_cnt_q <= feed_cnt_d;
    end
  end

  assign psel_o     = in_xfer;
  assign penable_o  = in_xfer && access_q;
  assign pwrite_o   = in_xfer && xfer_write;
  assign paddr_o    = in_xfer ? (WDG_BASE + ADDR_WIDTH'(xfer_off)) : '0;
  assign pwdata_o   = (in_xfer && xfer_write) ? xfer_data : 32'h0;
  assign busy_o     = in_xfer;
  assign armed_o    = (state_q == ST_ARMED) || (state_q == ST_FEED);
  assign err_o      = err_q;
  assign hb_pend_o  = pend_q;
  assign feed_cnt_o = feed_cnt_q;

endmodule

// File: tb/tb_wdg_feed_ctrl.sv
// Directed bench for wdg_feed_ctrl: transfer tables for configuration and feeding, plus hand-written corner sequences.
// Inputs are driven and outputs sampled on the falling clock edge.
// Slave wait states and errors are injected per transfer.
module tb_wdg_feed_ctrl;

  localparam logic [31:0] KEY = 32'h5F37_59DF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic [19:0] pscr_i = '0;
  logic [31:0] cmp_i = '0;
  logic [3:0]  hb_i = '0;
  logic [31:0] prdata_i = '0;
  logic        pready_i = 1'b1;
  logic        pslverr_i = 1'b0;
  logic [31:0] paddr_o;
  logic        psel_o, penable_o, pwrite_o;
  logic [31:0] pwdata_o;
  logic        busy_o, armed_o, err_o;
  logic [3:0]  hb_pend_o;
  logic [15:0] feed_cnt_o;

  wdg_feed_ctrl #(.NUM_SRC(4), .ADDR_WIDTH(32), .WDG_BASE(32'h0), .PSCR_WIDTH(20), .CMP_WIDTH(32)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start_i), .pscr_i(pscr_i), .cmp_i(cmp_i), .hb_i(hb_i),
    .paddr_o(paddr_o), .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o), .pwdata_o(pwdata_o),
    .prdata_i(prdata_i), .pready_i(pready_i), .pslverr_i(pslverr_i), .busy_o(busy_o), .armed_o(armed_o),
    .err_o(err_o), .hb_pend_o(hb_pend_o), .feed_cnt_o(feed_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        wr;
  } xfer_t;

  xfer_t cfg_tab [8];
  xfer_t feed_tab [4];
  int    n_cfg;
  int    checks = 0;
  int    errors = 0;

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic build_cfg(input logic [31:0] pscr, input logic [31:0] cmp);
    cfg_tab[0] = '{32'h14, KEY,   1'b1};
    cfg_tab[1] = '{32'h04, pscr,  1'b1};
    cfg_tab[2] = '{32'h14, KEY,   1'b1};
    cfg_tab[3] = '{32'h0C, cmp,   1'b1};
    cfg_tab[4] = '{32'h14, KEY,   1'b1};
    cfg_tab[5] = '{32'h00, 32'h3, 1'b1};
    cfg_tab[6] = '{32'h0C, cmp,   1'b0};
    cfg_tab[7] = '{32'h00, 32'h3, 1'b0};
`ifdef WDG_FEED_CTRL_VERIFY_EN
    n_cfg = 8;
`else
    n_cfg = 6;
`endif
  endtask

  // One APB transfer: SETUP then ACCESS held for waits extra cycles; serr flags the completing cycle.
  task automatic do_xfer(input xfer_t x, input int waits, input logic serr, input int exp_armed, input string tag);
    chk({tag, " setup psel"}, 32'(psel_o), 32'd1);
    chk({tag, " setup penable"}, 32'(penable_o), 32'd0);
    chk({tag, " setup paddr"}, paddr_o, x.addr);
    chk({tag, " setup pwrite"}, 32'(pwrite_o), 32'(x.wr));
    if (x.wr) chk({tag, " setup pwdata"}, pwdata_o, x.data);
    chk({tag, " setup busy"}, 32'(busy_o), 32'd1);
    if (exp_armed >= 0) chk({tag, " armed"}, 32'(armed_o), 32'(exp_armed));
    tick;
    for (int k = 0; k <= waits; k++) begin
      chk({tag, " access psel"}, 32'(psel_o), 32'd1);
      chk({tag, " access penable"}, 32'(penable_o), 32'd1);
      chk({tag, " access paddr"}, paddr_o, x.addr);
      if (x.wr) chk({tag, " access pwdata"}, pwdata_o, x.data);
      pready_i  = (k == waits);
      pslverr_i = (k == waits) && serr;
      prdata_i  = x.data;
      tick;
    end
    pready_i  = 1'b1;
    pslverr_i = 1'b0;
  endtask

  // Start a configuration run; the armed check lands exactly one cycle after the last transfer completes.
  task automatic run_cfg(input logic [31:0] pscr, input logic [31:0] cmp, input int wait_idx, input int waits, input int err_idx);
    build_cfg(pscr, cmp);
    pscr_i  = pscr[19:0];
    cmp_i   = cmp;
    start_i = 1'b1;
    tick;
    start_i = 1'b0;
    chk("err cleared by start", 32'(err_o), 32'd0);
    for (int i = 0; i < n_cfg; i++) begin
      do_xfer(cfg_tab[i], (i == wait_idx) ? waits : 0, (i == err_idx), 0, $sformatf("cfg%0d", i));
      if (i == err_idx) break;
    end
    if (err_idx < 0) begin
      chk("armed after cfg", 32'(armed_o), 32'd1);
      chk("busy after cfg", 32'(busy_o), 32'd0);
      chk("psel after cfg", 32'(psel_o), 32'd0);
    end else begin
      for (int c = 0; c < 4; c++) begin
        chk("psel after slverr", 32'(psel_o), 32'd0);
        tick;
      end
      chk("err after slverr", 32'(err_o), 32'd1);
      chk("armed after slverr", 32'(armed_o), 32'd0);
      chk("busy after slverr", 32'(busy_o), 32'd0);
    end
  endtask

  task automatic run_feed(input logic [15:0] exp_cnt, input logic [3:0] exp_pend);
    for (int i = 0; i < 4; i++) do_xfer(feed_tab[i], 0, 1'b0, -1, $sformatf("feed%0d", i));
    chk("feed_cnt after feed", 32'(feed_cnt_o), 32'(exp_cnt));
    chk("hb_pend after feed", 32'(hb_pend_o), 32'(exp_pend));
    chk("armed after feed", 32'(armed_o), 32'd1);
    chk("psel after feed", 32'(psel_o), 32'd0);
  endtask

  task automatic pulse_hb(input logic [3:0] v);
    hb_i = v;
    tick;
    hb_i = '0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    tick;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " psel"}, 32'(psel_o), 32'd0);
    chk({tag, " penable"}, 32'(penable_o), 32'd0);
    chk({tag, " pwrite"}, 32'(pwrite_o), 32'd0);
    chk({tag, " paddr"}, paddr_o, 32'd0);
    chk({tag, " pwdata"}, pwdata_o, 32'd0);
    chk({tag, " busy"}, 32'(busy_o), 32'd0);
    chk({tag, " armed"}, 32'(armed_o), 32'd0);
    chk({tag, " err"}, 32'(err_o), 32'd0);
    chk({tag, " hb_pend"}, 32'(hb_pend_o), 32'd0);
    chk({tag, " feed_cnt"}, 32'(feed_cnt_o), 32'd0);
  endtask

  initial begin
    feed_tab[0] = '{32'h14, KEY,   1'b1};
    feed_tab[1] = '{32'h18, 32'h1, 1'b1};
    feed_tab[2] = '{32'h14, KEY,   1'b1};
    feed_tab[3] = '{32'h18, 32'h0, 1'b1};

    // Reset state.
    tick;
    chk_all_zero("reset");
    rst = 1'b0;
    tick;

    // Full configuration, zero wait states.
    run_cfg(32'h20, 32'h100, -1, 0, -1);
    chk("hb_pend after cfg", 32'(hb_pend_o), 32'd0);

    // Three sources only: no feed may start.
    pulse_hb(4'b0001);
    pulse_hb(4'b0010);
    pulse_hb(4'b0100);
    for (int c = 0; c < 5; c++) begin
      chk("no feed with partial hb", 32'(psel_o), 32'd0);
      tick;
    end
    chk("hb_pend partial", 32'(hb_pend_o), 32'h7);
    pulse_hb(4'b1000);
    chk("hb_pend full", 32'(hb_pend_o), 32'hF);
    tick;
    run_feed(16'd1, 4'b0000);

    // Heartbeat in the same cycle FEED is entered stays pending.
    pulse_hb(4'b0111);
    pulse_hb(4'b1000);
    pulse_hb(4'b0001);
    chk("hb_pend at feed entry", 32'(hb_pend_o), 32'h1);
    run_feed(16'd2, 4'b0001);

    // Wait states on the CMP write: 3 low-ready cycles, 15-cycle configuration.
    do_reset();
    run_cfg(32'h0ABCD, 32'hDEAD_BEEF, 3, 3, -1);

    // Slave error on the PSCR write, then a clean restart from ERR.
    do_reset();
    run_cfg(32'h20, 32'h100, -1, 0, 1);
    run_cfg(32'h33, 32'h4444, -1, 0, -1);
    chk("err after restart", 32'(err_o), 32'd0);

    // Reset asserted during a FEED ACCESS cycle.
    pulse_hb(4'b1111);
    tick;
    run_feed(16'd1, 4'b0000);
    pulse_hb(4'b1111);
    tick;
    chk("feed setup before reset", 32'(psel_o), 32'd1);
    tick;
    chk("feed access before reset", 32'(penable_o), 32'd1);
    rst = 1'b1;
    #1;
    chk_all_zero("async reset");
    tick;
    rst = 1'b0;
    tick;
    chk_all_zero("after reset release");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
